// File: rtl/mips_cpu_pc_fetch_if.sv
// Fetch-stage bus between the PC/fetch block, instruction memory and the control decoder.
// MIPS_FETCH_ALIGN_CHECK_EN adds the fetch_fault status signal.
interface mips_cpu_pc_fetch_if;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [5:0]  opcode;
    logic [4:0]  branch_type;
    logic        branch;
    logic        branch_cond;
    logic        jump;
    logic        jump_reg;
    logic [31:0] rs_data;
    logic [31:0] link_addr;
    logic        active;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;

    modport master (
        input  clk_enable, instr_readdata, branch, branch_cond, jump, jump_reg, rs_data,
        output instr_address, opcode, branch_type, link_addr, active, fetch_fault
    );
    modport slave (
        output clk_enable, instr_readdata, branch, branch_cond, jump, jump_reg, rs_data,
        input  instr_address, opcode, branch_type, link_addr, active, fetch_fault
    );
`else
    modport master (
        input  clk_enable, instr_readdata, branch, branch_cond, jump, jump_reg, rs_data,
        output instr_address, opcode, branch_type, link_addr, active
    );
    modport slave (
        output clk_enable, instr_readdata, branch, branch_cond, jump, jump_reg, rs_data,
        input  instr_address, opcode, branch_type, link_addr, active
    );
`endif
endinterface

// File: rtl/mips_cpu_pc_fetch.sv
// PC and instruction-fetch stage with a one-entry branch-delay-slot target and halt at address 0.
// Optional feature macro: MIPS_FETCH_ALIGN_CHECK_EN (misaligned redirect target raises fetch_fault).
module mips_cpu_pc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_cpu_pc_fetch_if.master     bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [31:0] r_pc;
    logic [31:0] r_pendingTarget;
    logic [1:0]  r_state;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_branchOffset;
    logic [31:0] w_target;
    logic [31:0] w_captureTarget;
    logic        w_redirect;
    logic        w_targetFault;

    assign w_pcPlus4      = r_pc + 32'd4;
    assign w_branchOffset = {{14{bus.instr_readdata[15]}}, bus.instr_readdata[15:0], 2'b00};
    assign w_redirect     = bus.jump | bus.jump_reg | (bus.branch & bus.branch_cond);

    // jump_reg beats jump beats a taken conditional branch
    always_comb begin
        w_target = w_pcPlus4 + w_branchOffset;
        if (bus.jump_reg)
            w_target = bus.rs_data;
        else if (bus.jump)
            w_target = {w_pcPlus4[31:28], bus.instr_readdata[25:0], 2'b00};
    end

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    logic r_fetchFault;

    assign w_captureTarget = w_target;
    assign w_targetFault   = (r_pendingTarget[1:0] != 2'b00);
    assign bus.fetch_fault = r_fetchFault;

    always_ff @(posedge clk) begin
        if (reset)
            r_fetchFault <= 1'b0;
        else if (bus.clk_enable && r_state == ST_DELAY && w_targetFault)
            r_fetchFault <= 1'b1;
    end
`else
    assign w_captureTarget = w_target & ~32'h3;
    assign w_targetFault   = 1'b0;
`endif

    // The DELAY state itself marks the pending target as valid; leaving it consumes the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_VECTOR;
            r_pendingTarget <= 32'd0;
            r_state         <= ST_RUN;
        end else if (bus.clk_enable) begin
            case (r_state)
                ST_RUN: begin
                    r_pc <= w_pcPlus4;
                    if (w_redirect) begin
                        r_pendingTarget <= w_captureTarget;
                        r_state         <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (w_targetFault || r_pendingTarget == 32'd0) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_pc    <= r_pendingTarget;
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign bus.instr_address = r_pc;
    assign bus.link_addr     = r_pc + 32'd8;
    assign bus.opcode        = bus.instr_readdata[31:26];
    assign bus.branch_type   = bus.instr_readdata[20:16];
    assign bus.active        = (r_state != ST_HALT);

endmodule

// File: tb/tb_mips_cpu_pc_fetch.sv
// Self-checking bench for mips_cpu_pc_fetch: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the fetch stage.
module tb_mips_cpu_pc_fetch;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    mips_cpu_pc_fetch_if bus ();

    mips_cpu_pc_fetch #(.RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of pending targets plus halt/fault flags.
    logic [31:0] mPc;
    logic [31:0] mQ[$];
    logic        mHalted;
    logic        mFault;
    bit          modelValid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic rst, input logic en, input logic [31:0] instr,
                             input logic br, input logic bc, input logic jp, input logic jr,
                             input logic [31:0] rs);
        logic [31:0] t;
        logic [31:0] next;
        if (rst) begin
            mPc = RV; mQ.delete(); mHalted = 1'b0; mFault = 1'b0; modelValid = 1'b1;
        end else if (en && !mHalted && modelValid) begin
            if (mQ.size() > 0) begin
                t = mQ.pop_front();
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
                if (t % 4 != 0) begin mFault = 1'b1; mHalted = 1'b1; end
                else if (t == 0) mHalted = 1'b1;
                else mPc = t;
`else
                t = (t / 4) * 4;
                if (t == 0) mHalted = 1'b1;
                else mPc = t;
`endif
            end else begin
                next = mPc + 4;
                if (jr)
                    mQ.push_back(rs);
                else if (jp)
                    mQ.push_back((next & 32'hF000_0000) + (instr % (1 << 26)) * 4);
                else if (br && bc)
                    mQ.push_back(next + 32'(int'($signed(instr[15:0])) * 4));
                mPc = next;
            end
        end
    endtask

    task automatic sampleOutputs(input logic [31:0] instr);
        checkOutput("instr_address", bus.instr_address, mPc);
        checkOutput("link_addr", bus.link_addr, mPc + 8);
        checkOutput("active", 32'(bus.active), 32'(!mHalted));
        checkOutput("opcode", 32'(bus.opcode), instr >> 26);
        checkOutput("branch_type", 32'(bus.branch_type), (instr >> 16) % 32);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        checkOutput("fetch_fault", 32'(bus.fetch_fault), 32'(mFault));
`endif
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [31:0] instr,
                                 input logic br, input logic bc, input logic jp, input logic jr,
                                 input logic [31:0] rs);
        reset = rst; bus.clk_enable = en; bus.instr_readdata = instr;
        bus.branch = br; bus.branch_cond = bc; bus.jump = jp; bus.jump_reg = jr; bus.rs_data = rs;
        #1;
        if (modelValid) sampleOutputs(instr);
        @(posedge clk);
        modelStep(rst, en, instr, br, bc, jp, jr, rs);
        #1;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jrTo(input logic [31:0] rs);
        applyStimulus(1'b0, 1'b1, 32'h0020_0008, 1'b0, 1'b0, 1'b0, 1'b1, rs);
    endtask

    initial begin
        logic [31:0] instr;
        logic [31:0] frozen;
        checkCount = 0; errorCount = 0; modelValid = 1'b0;
        mPc = RV; mHalted = 1'b0; mFault = 1'b0;
        reset = 1'b1; bus.clk_enable = 1'b0; bus.instr_readdata = '0;
        bus.branch = 1'b0; bus.branch_cond = 1'b0; bus.jump = 1'b0; bus.jump_reg = 1'b0; bus.rs_data = '0;

        // Reset then sequential fetch
        doReset(2);
        checkOutput("reset_addr", bus.instr_address, 32'hBFC00000);
        checkOutput("reset_link", bus.link_addr, 32'hBFC00008);
        checkOutput("reset_active", 32'(bus.active), 32'd1);
        nop(); checkOutput("seq1", bus.instr_address, 32'hBFC00004);
        nop(); checkOutput("seq2", bus.instr_address, 32'hBFC00008);
        nop(); checkOutput("seq3", bus.instr_address, 32'hBFC0000C);
        checkOutput("seq3_link", bus.link_addr, 32'hBFC00014);

        // Taken BEQ with imm 3
        doReset(1);
        applyStimulus(1'b0, 1'b1, 32'h1000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("beq_slot", bus.instr_address, 32'hBFC00004);
        nop(); checkOutput("beq_target", bus.instr_address, 32'hBFC00010);

        // JR to 0 halts after the delay slot
        doReset(1);
        nop(); nop();
        jrTo(32'h0);
        checkOutput("jr0_slot", bus.instr_address, 32'hBFC0000C);
        nop();
        checkOutput("jr0_inactive", 32'(bus.active), 32'd0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        checkOutput("halt_hold", bus.instr_address, 32'hBFC0000C);

        // J with JAL in the delay slot
        doReset(1);
        applyStimulus(1'b0, 1'b1, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("j_slot", bus.instr_address, 32'hBFC00004);
        applyStimulus(1'b0, 1'b1, 32'h0C00_1234, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("j_target", bus.instr_address, 32'hB000_0100);

        // Freeze in DELAY, then reset discards the pending target
        doReset(1);
        jrTo(32'h8000_1000);
        frozen = bus.instr_address;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("freeze", bus.instr_address, frozen);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("reset_mid_delay", bus.instr_address, 32'hBFC00000);
        nop(); checkOutput("no_stale_target", bus.instr_address, 32'hBFC00004);

        // Misaligned JR target
        doReset(1);
        jrTo(32'h8000_0002);
        nop();
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        checkOutput("align_fault", 32'(bus.fetch_fault), 32'd1);
        checkOutput("align_halt", 32'(bus.active), 32'd0);
        checkOutput("align_pc", bus.instr_address, 32'hBFC00004);
`else
        checkOutput("align_masked", bus.instr_address, 32'h8000_0000);
`endif

        // Randomized traffic against the model
        doReset(1);
        for (int i = 0; i < 600; i++) begin
            logic rst, en, br, bc, jp, jr;
            logic [31:0] rs;
            instr = $urandom;
            rst = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 4) != 0);
            br  = ($urandom_range(0, 3) == 0);
            bc  = $urandom_range(0, 1) == 1;
            jp  = ($urandom_range(0, 9) == 0);
            jr  = ($urandom_range(0, 11) == 0);
            rs  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            applyStimulus(rst, en, instr, br, bc, jp, jr, rs);
        end
        instr = $urandom;
        bus.instr_readdata = instr;
        #1;
        sampleOutputs(instr);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
